// File: rtl/synth_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// synth_pkg : RAM bus constants and oscillator state encoding shared by the synth
// Rev 1.0
// -----------------------------------------------------------------------------
package synth_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 8;

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_FETCH_B = 3'd4,
    ST_WAIT_B  = 3'd5
  } osc_state_e;

endpackage

`default_nettype wire

// File: rtl/wavetable_lerp.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// wavetable_lerp : y = a + ((b - a) * frac) >>> FRAC_W, result always between a and b
// Rev 1.0
// -----------------------------------------------------------------------------
module wavetable_lerp #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [FRAC_W-1:0] frac,
  output logic [DATA_W-1:0] y
);

  localparam int PROD_W = DATA_W + FRAC_W + 2;

  logic signed [DATA_W:0]   diff;
  logic signed [PROD_W-1:0] prod;

  // The arithmetic shift floors toward minus infinity, which keeps a falling
  // segment from undershooting b.
  always_comb begin
    diff = $signed({1'b0, b}) - $signed({1'b0, a});
    prod = {{(PROD_W-DATA_W-1){diff[DATA_W]}}, diff} * {{(PROD_W-FRAC_W){1'b0}}, frac};
    y    = DATA_W'($signed({{(PROD_W-DATA_W){1'b0}}, a}) + (prod >>> FRAC_W));
  end

endmodule

`default_nettype wire

// File: rtl/wavetable_osc.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// wavetable_osc : phase-accumulator wavetable oscillator, master of the sample RAM
// Build option WAVETABLE_INTERP_EN adds a second read and linear interpolation.
// Rev 1.0
// -----------------------------------------------------------------------------
module wavetable_osc
  import synth_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = RAM_ADDR_W,
  parameter int DATA_W  = RAM_DATA_W
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Enable,
  input  logic [PHASE_W-1:0] Step,
  input  logic               SampleTick,
  output logic [DATA_W-1:0]  Sample,
  output logic               SampleValid,
  output logic               Overrun,
  input  logic               LoadValid,
  output logic               LoadReady,
  input  logic [ADDR_W-1:0]  LoadAddr,
  input  logic [DATA_W-1:0]  LoadData,
  output logic [ADDR_W-1:0]  RamAddress,
  inout  wire  [DATA_W-1:0]  RamData,
  output logic               RamReadWrite
);

  localparam int FRAC_W = PHASE_W - ADDR_W;

  osc_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               tick_live;
  logic               is_idle;

`ifdef WAVETABLE_INTERP_EN
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  lerp_y;

  wavetable_lerp #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_lerp (
    .a    (a_q),
    .b    (RamData),
    .frac (phase_q[FRAC_W-1:0]),
    .y    (lerp_y)
  );
`endif

  always_comb begin
    tick_live = SampleTick && Enable;
    is_idle   = (state_q == ST_IDLE);
    LoadReady = is_idle && !tick_live;

    state_d   = state_q;
    phase_d   = phase_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q || (tick_live && !is_idle);
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifdef WAVETABLE_INTERP_EN
    a_d       = a_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (tick_live) begin
          state_d = ST_FETCH;
          addr_d  = phase_q[PHASE_W-1 -: ADDR_W];
        end else if (LoadValid) begin
          state_d = ST_WRITE;
          addr_d  = LoadAddr;
          wdata_d = LoadData;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
`ifdef WAVETABLE_INTERP_EN
      ST_WAIT: begin
        a_d     = RamData;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_FETCH_B;
      end
      ST_FETCH_B: state_d = ST_WAIT_B;
      ST_WAIT_B: begin
        sample_d = lerp_y;
        valid_d  = 1'b1;
        phase_d  = phase_q + Step;
        state_d  = ST_IDLE;
      end
`else
      ST_WAIT: begin
        sample_d = RamData;
        valid_d  = 1'b1;
        phase_d  = phase_q + Step;
        state_d  = ST_IDLE;
      end
`endif
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifdef WAVETABLE_INTERP_EN
      a_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
`ifdef WAVETABLE_INTERP_EN
      a_q       <= a_d;
`endif
    end
  end

  // Direction and data enable both decode the state register: no contention cycle.
  assign RamReadWrite = (state_q == ST_WRITE) ? RAM_WRITE : RAM_READ;
  assign RamData      = (state_q == ST_WRITE) ? wdata_q : {DATA_W{1'bz}};
  assign RamAddress   = addr_q;
  assign Sample       = sample_q;
  assign SampleValid  = valid_q;
  assign Overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_wavetable_osc.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// tb_wavetable_osc : directed self-checking bench with a registered-read RAM model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_wavetable_osc;

`ifdef WAVETABLE_INTERP_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] step_inc;
  logic        sample_tick;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        overrun;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;
  logic [7:0]  ram_addr;
  wire  [7:0]  ram_data;
  logic        ram_rw;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [256];
  logic [7:0] ram_rd_q;

  assign ram_data = (ram_rw == 1'b0) ? ram_rd_q : 8'hzz;

  always @(posedge clk) begin
    if (ram_rw) mem[ram_addr] <= ram_data;
    ram_rd_q <= mem[ram_addr];
  end

  wavetable_osc dut (
    .Clock        (clk),
    .Reset        (rst),
    .Enable       (enable),
    .Step         (step_inc),
    .SampleTick   (sample_tick),
    .Sample       (sample),
    .SampleValid  (sample_valid),
    .Overrun      (overrun),
    .LoadValid    (load_valid),
    .LoadReady    (load_ready),
    .LoadAddr     (load_addr),
    .LoadData     (load_data),
    .RamAddress   (ram_addr),
    .RamData      (ram_data),
    .RamReadWrite (ram_rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d, input bit check_it);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    #1;
    if (check_it) chk("load_ready_idle", 32'(load_ready), 1);
    step();
    load_valid = 1'b0;
    #1;
    if (check_it) begin
      chk("load_rw", 32'(ram_rw), 1);
      chk("load_addr", 32'(ram_addr), 32'(a));
      chk("load_bus", 32'(ram_data), 32'(d));
      chk("load_ready_busy", 32'(load_ready), 0);
    end
    step();
  endtask

  // Tick in the current cycle T; returns in cycle T+LAT after checking the pulse.
  task automatic tick_read(input logic [7:0] exp_addr, input logic [7:0] exp_sample);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("fetch_addr", 32'(ram_addr), 32'(exp_addr));
    chk("fetch_rw", 32'(ram_rw), 0);
    for (int c = 1; c < LAT; c++) begin
      chk("valid_early", 32'(sample_valid), 0);
      step();
    end
    chk("valid_pulse", 32'(sample_valid), 1);
    chk("sample_val", 32'(sample), 32'(exp_sample));
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b0;
    step_inc    = 16'h0000;
    sample_tick = 1'b0;
    load_valid  = 1'b0;
    load_addr   = 8'h00;
    load_data   = 8'h00;
    step();
    step();
    step();

    chk("rst_sample", 32'(sample), 0);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_rw", 32'(ram_rw), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_load_ready", 32'(load_ready), 1);
    chk("rst_bus_owner", 32'(ram_data), 32'(ram_rd_q));
    rst = 1'b0;
    step();

    load(8'h00, 8'h00, 1'b1);
    load(8'h01, 8'h02, 1'b1);
    for (int i = 2; i < 256; i++) load(8'(i), 8'(2 * i), 1'b0);

    // Sweep the whole table once and one step past the wrap.
    enable   = 1'b1;
    step_inc = 16'h0100;
    step();
    for (int k = 0; k < 257; k++) begin
      chk("idle_valid", 32'(sample_valid), 0);
      tick_read(8'(k & 255), 8'((2 * k) & 255));
      step();
    end
    chk("sweep_overrun", 32'(overrun), 0);

    // Tick and load in the same idle cycle: the read wins.
    sample_tick = 1'b1;
    load_valid  = 1'b1;
    load_addr   = 8'h01;
    load_data   = 8'h77;
    #1;
    chk("tie_load_ready", 32'(load_ready), 0);
    step();
    sample_tick = 1'b0;
    #1;
    chk("tie_fetch_addr", 32'(ram_addr), 1);
    chk("tie_fetch_rw", 32'(ram_rw), 0);
    chk("tie_ready_fetch", 32'(load_ready), 0);
    for (int c = 2; c < LAT; c++) begin
      step();
      chk("tie_ready_busy", 32'(load_ready), 0);
    end
    step();
    chk("tie_valid", 32'(sample_valid), 1);
    chk("tie_sample", 32'(sample), 8'h02);
    chk("tie_ready_late", 32'(load_ready), 1);
    step();
    load_valid = 1'b0;
    chk("tie_write_rw", 32'(ram_rw), 1);
    chk("tie_write_addr", 32'(ram_addr), 1);
    chk("tie_write_bus", 32'(ram_data), 8'h77);
    chk("tie_write_valid", 32'(sample_valid), 0);
    step();
    chk("tie_write_done", 32'(ram_rw), 0);

    // Back-to-back ticks: second is dropped and flags overrun. Phase is 0x0200.
    step_inc    = 16'hFF00;
    sample_tick = 1'b1;
    step();
    chk("ovr_before", 32'(overrun), 0);
    step();
    sample_tick = 1'b0;
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_valid_t2", 32'(sample_valid), 0);
    for (int c = 3; c < LAT; c++) begin
      step();
      chk("ovr_valid_mid", 32'(sample_valid), 0);
    end
    step();
    chk("ovr_valid", 32'(sample_valid), 1);
    chk("ovr_sample", 32'(sample), 8'h04);
    tick_read(8'h01, 8'h77);
    chk("ovr_sticky", 32'(overrun), 1);
    step();

    // Disabled: ticks ignored, nothing moves.
    enable      = 1'b0;
    sample_tick = 1'b1;
    #1;
    chk("dis_load_ready", 32'(load_ready), 1);
    step();
    sample_tick = 1'b0;
    for (int c = 0; c < LAT; c++) begin
      chk("dis_valid", 32'(sample_valid), 0);
      chk("dis_sample", 32'(sample), 8'h77);
      step();
    end

    // Reset in the middle of a read. Phase is 0x0000 here.
    enable   = 1'b1;
    step_inc = 16'h0100;
    tick_read(8'h00, 8'h00);
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_sample", 32'(sample), 0);
    chk("mid_rst_valid", 32'(sample_valid), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_rw", 32'(ram_rw), 0);
    chk("mid_rst_addr", 32'(ram_addr), 0);
    chk("mid_rst_ready", 32'(load_ready), 1);
    chk("mid_rst_bus_owner", 32'(ram_data), 32'(ram_rd_q));
    rst = 1'b0;
    step();
    tick_read(8'h00, 8'h00);
    step();

`ifdef WAVETABLE_INTERP_EN
    load(8'h00, 8'h10, 1'b0);
    load(8'h01, 8'h30, 1'b0);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    step_inc = 16'h0080;
    step();
    tick_read(8'h00, 8'h10);
    step();
    tick_read(8'h00, 8'h20);
    step();
    tick_read(8'h01, 8'h30);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wavetable_osc.md
# wavetable_osc

Wavetable oscillator acting as bus master of the synth's 8-bit sample RAM. On each sample-rate strobe it advances a phase accumulator, reads the addressed table entry through the RAM's single shared Address/Data/ReadWrite port, and presents the sample downstream. It also owns the RAM write path, through a valid/ready load interface used to fill the table.

## Interface
- PHASE_W, 16, phase accumulator width; upper ADDR_W bits = table address, lower bits = fraction
- ADDR_W, 8, RAM address width
- DATA_W, 8, sample width (unsigned)
- Clock  in  1  sole clock, all logic on posedge
- Reset  in  1  synchronous, active-high
- Enable  in  1  oscillator run; low = ticks ignored, phase held
- Step  in  PHASE_W  phase increment per tick
- SampleTick  in  1  one-cycle sample-rate strobe
- Sample  out  DATA_W  last produced sample, held between updates
- SampleValid  out  1  one-cycle pulse when Sample updates
- Overrun  out  1  sticky; a tick arrived while not IDLE
- LoadValid  in  1  table write request
- LoadReady  out  1  write accepted this cycle (combinational)
- LoadAddr  in  ADDR_W  table write address
- LoadData  in  DATA_W  table write data
- RamAddress  out  ADDR_W  to RAM Address
- RamData  inout  DATA_W  to RAM Data; driven only when RamReadWrite=1, else Z
- RamReadWrite  out  1  1 = write, 0 = read (default)

## Operation
- FSM states: IDLE, FETCH, WAIT, WRITE (+ FETCH_B, WAIT_B with interpolation).
- IDLE: RamReadWrite=0, RamData=Z. Tick accepted if Enable=1 -> FETCH. Otherwise, LoadValid -> WRITE.
- Tick has priority. LoadReady = IDLE && LoadValid-independent && !(SampleTick && Enable).
- FETCH: RamAddress = phase[PHASE_W-1 -: ADDR_W], RamReadWrite=0 -> WAIT.
- WAIT: the RAM drives the registered read data. At the edge: Sample <= RamData, SampleValid <= 1, phase <= phase + Step (mod 2^PHASE_W) -> IDLE.
- WRITE: RamAddress/RamData = the LoadAddr/LoadData captured at handshake, RamReadWrite=1 for exactly one cycle -> IDLE.
- Step is sampled at the phase-update edge.
- Enable=0: no reads; phase, Sample held; SampleValid=0. An in-flight read completes.
- Tick while not IDLE: dropped, no queueing, Overrun <= 1. Cleared only by Reset.
- Address wrap: 0xFF+1 -> 0x00 via phase modulo.
- Reset (any state, including mid-read or mid-write): state=IDLE, phase=0, Sample=0, SampleValid=0, Overrun=0, RamReadWrite=0, RamAddress=0, RamData=Z. An interrupted write may not land.

## Timing
- Tick high in cycle T -> FETCH T+1, WAIT T+2, SampleValid high in T+3 only, phase updated in T+3.
- With interpolation: SampleValid in T+5.
- Max tick rate without overrun: one per 3 cycles (5 with interpolation). A tick in exactly cycle T+3 is accepted.
- Load handshake in cycle L -> RAM write at edge ending L+1. LoadReady=0 during L+1; next load possible L+2.
- RamReadWrite and RamData enable both come from the same state register, so there is no bus contention cycle.

## Configuration
- WAVETABLE_INTERP_EN defined:
  - Adds a second read of address A+1 (wrapping 0xFF -> 0x00).
  - Output = a + (((b - a) as signed DATA_W+1) * frac) >>> (PHASE_W-ADDR_W); the result always lies between a and b.
- WAVETABLE_INTERP_EN undefined:
  - Nearest-lower sample only; frac bits ignored; 3-cycle latency.

## Structure
- Shared synth_pkg holds the FSM state encoding, RAM_ADDR_W/RAM_DATA_W constants and RAM_READ/RAM_WRITE levels, all shared with the RAM block.
- One combinational sub-module, wavetable_lerp (a, b, frac -> y). It is instantiated only under WAVETABLE_INTERP_EN.

## Test plan
- Reset asserted mid-WAIT -> next cycle Sample=0, SampleValid=0, Overrun=0, RamReadWrite=0, RamData=Z, state IDLE.
- Load Mem[i]=2i for i=0..255, Step=0x0100, tick every 4 cycles -> Samples 0x00, 0x02, 0x04…, each SampleValid exactly 3 cycles after its tick.
- Phase preset to 0xFF00 via ticks, Step=0x0100 -> read address 0xFF then 0x00; Sample 0xFE then 0x00.
- Ticks at T and T+1 -> one SampleValid at T+3, Overrun=1 from T+2 onward; tick at T+3 accepted normally.
- SampleTick and LoadValid in the same IDLE cycle -> LoadReady=0, read proceeds. Load is accepted in cycle T+3 and RamReadWrite=1 in T+4.
- With WAVETABLE_INTERP_EN: Mem[0]=0x10, Mem[1]=0x30, Step=0x0080 -> Samples 0x10, 0x20, 0x30 at latency 5.
